rtc_bus_arbiter: RTL
====================

Name: rtc_bus_arbiter

Overview:
- Owns the RTC multiplexed address/data bus (AD, CS, RD, WR strobes plus 8-bit AD bus).
- Arbitrates between two requesters: the write path (set-time/programming) and the read path (periodic time refresh for VGA).
- Sequences each granted request as one complete bus transaction: address phase, gap, data phase, recovery.
- Sits between the write/read datapaths and the top-level RTC pins; it is the only block that drives those pins.

Parameters:
- T_ADDR, 10, clk cycles the address phase is held (AD=0, CS=0, WR=0, address driven).
- T_GAP, 5, clk cycles with all strobes high between the address and data phases.
- T_DATA, 10, clk cycles the data phase is held (AD=1, CS=0, WR=0 or RD=0).
- T_REC, 5, clk cycles of recovery, all strobes high, before done.
- CW, 8, width of the phase counter; every T_* must be at most 2^CW-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_req  in  1  write request, level, held until wr_done
- wr_addr  in  8  RTC register address for the write
- wr_data  in  8  data byte to write
- wr_done  out  1  one-cycle pulse when the write transaction ends
- rd_req  in  1  read request, level, held until rd_done
- rd_addr  in  8  RTC register address for the read
- rd_data  out  8  last read byte, held until the next read completes
- rd_done  out  1  one-cycle pulse when the read ends; rd_data is valid in that cycle
- busy  out  1  high while any transaction is in progress (state not IDLE)
- ad_out  out  8  value driven on the AD bus
- ad_oe  out  1  AD bus output enable; the top-level tristate is controlled by this
- ad_in  in  8  AD bus input
- ADW  out  1  address/data select: 0 = address phase, 1 = data phase
- CSW  out  1  chip select, active low
- RDW  out  1  read strobe, active low
- WRW  out  1  write strobe, active low

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; ADW=CSW=RDW=WRW=1; ad_oe=0; ad_out=0; rd_data=0; wr_done=rd_done=0; busy=0; counter=0; last_grant=READ.
- States: IDLE -> ADDR -> GAP -> DATA -> REC -> IDLE.
- IDLE, arbitration:
  - If exactly one request is high, it is granted on the next clk edge.
  - If both are high, the requester not equal to last_grant wins (round-robin). The first tie after reset therefore goes to write.
  - On grant: latch op (WRITE/READ), the address, and the write data into internal registers; update last_grant; enter ADDR with counter=0.
- ADDR: ADW=0, CSW=0, WRW=0, RDW=1, ad_oe=1, ad_out=latched address. Stay T_ADDR cycles.
- GAP: all strobes 1. ad_oe stays 1 for writes (bus pre-driven with data), 0 for reads. ad_out=latched data for writes. Stay T_GAP cycles.
- DATA, write: ADW=1, CSW=0, WRW=0, RDW=1, ad_oe=1, ad_out=latched data.
- DATA, read: ADW=1, CSW=0, RDW=0, WRW=1, ad_oe=0.
- DATA timing: stay T_DATA cycles. For reads, ad_in is sampled into a capture register on the last DATA cycle, before RDW rises.
- REC: all strobes 1, ad_oe=0. Stay T_REC cycles. On the final REC cycle, pulse wr_done or rd_done for one cycle (matching the latched op). rd_data updates from the capture register in that same cycle.
- Phase exit: a phase lasts exactly its T_* cycles; the counter clears on every phase change. A T_* value of 0 is treated as 1.
- Latency, grant to done: T_ADDR+T_GAP+T_DATA+T_REC cycles. Request-high to done: that value +1 (the arbitration cycle). Defaults: 30 and 31.
- Requests, addresses and data are ignored outside IDLE. Input changes mid-transaction have no effect on the bus.
- A request deasserted mid-transaction does not abort it; the done pulse still occurs.
- A request still high in the cycle after done is re-arbitrated in IDLE, with a minimum of one IDLE cycle between transactions. With both requests permanently high, grants alternate W, R, W, R...
- Only one of wr_done/rd_done is ever high in a cycle. CSW is never low in IDLE or GAP.
- Reset asserted mid-transaction: strobes return high asynchronously and no done pulse is issued. The interrupted request is re-arbitrated after reset release if still high.
- All outputs are registered (no combinational path from inputs to pins).

Test Plan:
- Reset/idle: hold rst=1 for 3 cycles, then release -> ADW=CSW=RDW=WRW=1, ad_oe=0, busy=0, rd_data=8'h00.
- Single write: wr_req=1, wr_addr=8'h21, wr_data=8'h45, defaults:
  - ADDR: ADW=0/CSW=0/WRW=0 with ad_out=8'h21 for 10 cycles.
  - GAP: 5 cycles, strobes high.
  - DATA: ADW=1/CSW=0/WRW=0 with ad_out=8'h45 for 10 cycles.
  - REC: 5 cycles.
  - wr_done pulses exactly 31 cycles after wr_req rises; RDW stays 1 throughout.
- Single read: rd_req=1, rd_addr=8'h22, ad_in=8'h37 during DATA -> ad_oe=0 in GAP/DATA, RDW=0 for 10 cycles, rd_done pulses once, rd_data=8'h37 from that cycle onward.
- Contention: wr_req=rd_req=1 from reset, held -> order W, R, W; each done is followed by at least one IDLE cycle (busy=0).
- Mid-op reset: assert rst during the DATA phase of a write -> CSW/WRW go high in the same cycle without a clock edge, no wr_done pulse; after release with wr_req still 1, a fresh full transaction completes.
- Glitch immunity: change wr_addr to 8'hFF and drop wr_req during GAP -> bus still carries the originally latched data, wr_done still pulses.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: owner of the RTC multiplexed address/data bus.
// Arbitrates round-robin between the write path (time programming) and the read path
// (periodic time refresh), then runs each grant as one address/gap/data/recovery transaction.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data        - write request (level), target register, data byte
//   wr_done                       - one-cycle pulse at the end of a write
//   rd_req/rd_addr                - read request (level), target register
//   rd_data/rd_done               - last read byte (held) and its one-cycle completion pulse
//   busy                          - high while a transaction is in progress
//   ad_out/ad_oe/ad_in            - AD bus drive value, drive enable, sampled input
//   ADW/CSW/RDW/WRW               - address/data select, chip select, read and write strobes
// All outputs are flops; they are loaded from the next-state values so they line up with
// the state register.
module rtc_bus_arbiter #(
  parameter int unsigned T_ADDR = 10,
  parameter int unsigned T_GAP  = 5,
  parameter int unsigned T_DATA = 10,
  parameter int unsigned T_REC  = 5,
  parameter int unsigned CW     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_done,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output logic       busy,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       ADW,
  output logic       CSW,
  output logic       RDW,
  output logic       WRW
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAddr = 3'd1;
  localparam logic [2:0] StGap  = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StRec  = 3'd4;

  localparam logic OpRead  = 1'b0;
  localparam logic OpWrite = 1'b1;

  // Final counter value of each phase; a zero length behaves as one cycle.
  localparam logic [CW-1:0] AddrLast = (T_ADDR == 0) ? '0 : CW'(T_ADDR - 1);
  localparam logic [CW-1:0] GapLast  = (T_GAP  == 0) ? '0 : CW'(T_GAP  - 1);
  localparam logic [CW-1:0] DataLast = (T_DATA == 0) ? '0 : CW'(T_DATA - 1);
  localparam logic [CW-1:0] RecLast  = (T_REC  == 0) ? '0 : CW'(T_REC  - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic          last_q, last_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    capture_q, capture_d;

  logic       adw_d, csw_d, rdw_d, wrw_d, oe_d, busy_d;
  logic       done_d, wr_done_d, rd_done_d;
  logic [7:0] ad_d, rd_data_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    op_d      = op_q;
    last_d    = last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    capture_d = capture_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // On a tie the requester that was not served last wins.
        if (wr_req && (!rd_req || last_q == OpRead)) begin
          state_d = StAddr;
          op_d    = OpWrite;
          last_d  = OpWrite;
          addr_d  = wr_addr;
          data_d  = wr_data;
        end else if (rd_req) begin
          state_d = StAddr;
          op_d    = OpRead;
          last_d  = OpRead;
          addr_d  = rd_addr;
        end
      end
      StAddr: if (cnt_q == AddrLast) begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: if (cnt_q == GapLast) begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: if (cnt_q == DataLast) begin
        state_d = StRec;
        cnt_d   = '0;
        // Capture on the last data cycle, while RDW is still low.
        if (op_q == OpRead) capture_d = ad_in;
      end
      StRec: if (cnt_q == RecLast) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    adw_d = 1'b1;
    csw_d = 1'b1;
    rdw_d = 1'b1;
    wrw_d = 1'b1;
    oe_d  = 1'b0;
    ad_d  = 8'h00;
    case (state_d)
      StAddr: begin
        adw_d = 1'b0;
        csw_d = 1'b0;
        wrw_d = 1'b0;
        oe_d  = 1'b1;
        ad_d  = addr_d;
      end
      StGap: if (op_d == OpWrite) begin
        // Pre-drive the write data so it is settled before the data strobe.
        oe_d = 1'b1;
        ad_d = data_d;
      end
      StData: begin
        csw_d = 1'b0;
        if (op_d == OpWrite) begin
          wrw_d = 1'b0;
          oe_d  = 1'b1;
          ad_d  = data_d;
        end else begin
          rdw_d = 1'b0;
        end
      end
      default: ;
    endcase
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StRec) && (cnt_d == RecLast);
    wr_done_d = done_d && (op_d == OpWrite);
    rd_done_d = done_d && (op_d == OpRead);
    rd_data_d = rd_done_d ? capture_d : rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OpRead;
      last_q    <= OpRead;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      capture_q <= 8'h00;
      ADW       <= 1'b1;
      CSW       <= 1'b1;
      RDW       <= 1'b1;
      WRW       <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out    <= 8'h00;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      rd_data   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      capture_q <= capture_d;
      ADW       <= adw_d;
      CSW       <= csw_d;
      RDW       <= rdw_d;
      WRW       <= wrw_d;
      ad_oe     <= oe_d;
      ad_out    <= ad_d;
      busy      <= busy_d;
      wr_done   <= wr_done_d;
      rd_done   <= rd_done_d;
      rd_data   <= rd_data_d;
    end
  end

endmodule
